vc_test_rand_delay_check_sink: RTL and testbench

VC_TEST_RAND_DELAY_CHECK_SINK -- requirements
Module: vc_test_rand_delay_check_sink

---
 rtl/vc_test_rand_delay_check_sink.sv | 204 ++++++++++++++++++++
 tb/tb_vc_test_rand_delay_check_sink.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_test_rand_delay_check_sink.sv
// Random-stall val/rdy sink that checks each accepted message against a preloaded expected memory.
// Optional VC_TEST_SINK_MASK_EN adds a per-entry don't-care mask written alongside the expected data.
module vc_test_rand_delay_check_sink #(
  parameter int          P_MSG_NBITS = 64,
  parameter int          P_NUM_MSGS  = 1024,
  parameter int          P_LANES     = 4,
  parameter logic [15:0] P_SEED      = 16'hACE1,
  localparam int         AW          = $clog2(P_NUM_MSGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             max_delay,
  input  logic [AW:0]            num_msgs,
  input  logic                   load_en,
  input  logic [AW-1:0]          load_addr,
  input  logic [P_MSG_NBITS-1:0] load_msg,
`ifdef VC_TEST_SINK_MASK_EN
  input  logic [P_MSG_NBITS-1:0] load_mask,
`endif
  input  logic                   val,
  output logic                   rdy,
  input  logic [P_MSG_NBITS-1:0] msg,
  output logic                   done,
  output logic [AW:0]            num_recv,
  output logic [15:0]            num_err,
  output logic                   err,
  output logic [AW-1:0]          err_idx,
  output logic [P_LANES-1:0]     err_lane,
  output logic [1:0]             dbg_state_o
);

  localparam int LW = P_MSG_NBITS / P_LANES;

  // Handshake: a message is accepted on any rising edge where val && rdy.
  // rdy is a pure function of state, so it never depends on val combinationally.
  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_READY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              load_q, load_d;
  logic [7:0]        count_q, count_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [AW:0]       num_recv_q, num_recv_d;
  logic [15:0]       num_err_q, num_err_d;
  logic              err_q, err_d;
  logic [AW-1:0]     err_idx_q, err_idx_d;
  logic [P_LANES-1:0] err_lane_q, err_lane_d;

  logic [P_MSG_NBITS-1:0] mem [P_NUM_MSGS];
  logic [P_MSG_NBITS-1:0] exp_msg;
  logic [P_MSG_NBITS-1:0] diff;
  logic [P_LANES-1:0]     lane_diff;
  logic [8:0]             divisor;
  logic [8:0]             rem;
  logic                   delay_zero;
  logic                   xfer;
  logic [AW:0]            recv_inc;

`ifdef VC_TEST_SINK_MASK_EN
  logic [P_MSG_NBITS-1:0] mask_mem [P_NUM_MSGS];

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr]      <= load_msg;
      mask_mem[load_addr] <= load_mask;
    end
  end

  assign diff = (msg ^ exp_msg) & ~mask_mem[num_recv_q[AW-1:0]];
`else
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_msg;
    end
  end

  assign diff = msg ^ exp_msg;
`endif

  // Combinational read: a same-cycle write to this address is seen only next cycle.
  assign exp_msg = mem[num_recv_q[AW-1:0]];

  always_comb begin
    lane_diff = '0;
    for (int i = 0; i < P_LANES; i++) begin
      lane_diff[i] = |diff[i*LW +: LW];
    end
  end

  // max_delay==0 gives a divisor of 1, so the remainder is 0 with no special case.
  assign divisor    = {1'b0, max_delay} + 9'd1;
  assign rem        = {1'b0, lfsr_q[7:0]} % divisor;
  assign delay_zero = (rem == 9'd0);
  assign xfer       = val && (state_q == S_READY);
  assign recv_inc   = num_recv_q + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    count_d    = count_q;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    num_recv_d = num_recv_q;
    num_err_d  = num_err_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    err_lane_d = err_lane_q;

    case (state_q)
      S_DELAY: begin
        if (num_recv_q >= num_msgs) begin
          state_d = S_DONE;
        end else if (load_q) begin
          load_d = 1'b0;
          if (delay_zero) state_d = S_READY;
          else            count_d = rem[7:0] - 8'd1;
        end else if (count_q == 8'd0) begin
          state_d = S_READY;
        end else begin
          count_d = count_q - 8'd1;
        end
      end

      S_READY: begin
        if (xfer) begin
          num_recv_d = recv_inc;
          if (|lane_diff) begin
            if (num_err_q != 16'hFFFF) num_err_d = num_err_q + 16'd1;
            if (!err_q) begin
              err_d      = 1'b1;
              err_idx_d  = num_recv_q[AW-1:0];
              err_lane_d = lane_diff;
            end
          end
          if (recv_inc >= num_msgs) begin
            state_d = S_DONE;
          end else if (!delay_zero) begin
            state_d = S_DELAY;
            count_d = rem[7:0] - 8'd1;
          end
        end else if (num_recv_q >= num_msgs) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // val while done is an overflow: counted every cycle it is high.
        if (val) begin
          if (num_err_q != 16'hFFFF) num_err_d = num_err_q + 16'd1;
          if (!err_q) begin
            err_d      = 1'b1;
            err_idx_d  = num_recv_q[AW-1:0];
            err_lane_d = '1;
          end
        end
        if (num_recv_q < num_msgs) begin
          state_d = S_DELAY;
          load_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_DELAY;
        load_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_DELAY;
      load_q     <= 1'b1;
      count_q    <= 8'd0;
      lfsr_q     <= P_SEED;
      num_recv_q <= '0;
      num_err_q  <= 16'd0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      err_lane_q <= '0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      count_q    <= count_d;
      lfsr_q     <= lfsr_d;
      num_recv_q <= num_recv_d;
      num_err_q  <= num_err_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      err_lane_q <= err_lane_d;
    end
  end

  assign rdy         = (state_q == S_READY);
  assign done        = (state_q == S_DONE);
  assign num_recv    = num_recv_q;
  assign num_err     = num_err_q;
  assign err         = err_q;
  assign err_idx     = err_idx_q;
  assign err_lane    = err_lane_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vc_test_rand_delay_check_sink.sv
// Directed bench for vc_test_rand_delay_check_sink: vector table plus hand-written corner sequences.
// Expected stall gaps come from an independent model of the 16-bit seeded LFSR.
module tb_vc_test_rand_delay_check_sink;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        reset_n;
  logic [7:0]  max_delay;
  logic [10:0] num_msgs;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [63:0] load_msg;
`ifdef VC_TEST_SINK_MASK_EN
  logic [63:0] load_mask;
  logic [63:0] mask_fill;
`endif
  logic        val;
  logic        rdy;
  logic [63:0] msg;
  logic        done;
  logic [10:0] num_recv;
  logic [15:0] num_err;
  logic        err;
  logic [9:0]  err_idx;
  logic [3:0]  err_lane;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] exp_mem [16];

  vc_test_rand_delay_check_sink #(
    .P_MSG_NBITS(64), .P_NUM_MSGS(1024), .P_LANES(4), .P_SEED(SEED)
  ) dut (
    .clk(clk), .reset_n(reset_n), .max_delay(max_delay), .num_msgs(num_msgs),
    .load_en(load_en), .load_addr(load_addr), .load_msg(load_msg),
`ifdef VC_TEST_SINK_MASK_EN
    .load_mask(load_mask),
`endif
    .val(val), .rdy(rdy), .msg(msg), .done(done), .num_recv(num_recv),
    .num_err(num_err), .err(err), .err_idx(err_idx), .err_lane(err_lane),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int model_d(input int md, input logic [15:0] l);
    if (md == 0) return 0;
    return int'(l[7:0]) % (md + 1);
  endfunction

  // driver tasks
  task automatic do_reset(input int md, input int nm, input int nload);
    reset_n   = 1'b0;
    val       = 1'b0;
    msg       = '0;
    load_en   = 1'b0;
    max_delay = 8'(md);
    num_msgs  = 11'(nm);
    #1;
    chk("reset_rdy", rdy, 0);
    chk("reset_done", done, 0);
    chk("reset_num_recv", num_recv, 0);
    chk("reset_num_err", num_err, 0);
    chk("reset_err", err, 0);
    chk("reset_err_idx", err_idx, 0);
    chk("reset_err_lane", err_lane, 0);
    for (int i = 0; i < nload; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 10'(i);
      load_msg  = exp_mem[i];
`ifdef VC_TEST_SINK_MASK_EN
      load_mask = mask_fill;
`endif
    end
    @(negedge clk);
    load_en = 1'b0;
    reset_n = 1'b1;
  endtask

  // Drives messages k0..k_end-1 with val held high; called just after reset release
  // (before the first rising edge) or at a falling edge. Gap = rdy-low cycles before each transfer.
  task automatic run_stream(input int md, input int k0, input int k_end, input int ci,
                            input logic [63:0] cx, input int post, input bit chk_gaps,
                            input bit chk_done);
    logic [15:0] lm;
    int k, gap, exp_gap, cyc;
    lm      = SEED;
    k       = k0;
    gap     = 0;
    cyc     = 0;
    exp_gap = 1 + model_d(md, lm);
    val     = 1'b1;
    while (k < k_end && cyc < 2000) begin
      msg = exp_mem[k] ^ ((k == ci) ? cx : 64'd0);
      if (rdy) begin
        if (chk_gaps) chk($sformatf("gap_before_msg%0d", k), 64'(gap), 64'(exp_gap));
        exp_gap = model_d(md, lm);
        gap     = 0;
        k++;
      end else begin
        gap++;
      end
      @(posedge clk);
      lm = lfsr_step(lm);
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (k < k_end) begin
      n_err++;
      $display("FAIL stream_timeout: accepted %0d required %0d", k, k_end);
    end
    if (chk_done) chk("done_after_last", done, 1);
    for (int i = 0; i < post; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rdy_low_in_done", rdy, 0);
    end
    val = 1'b0;
  endtask

  typedef struct {
    int          md;
    int          n;
    int          ci;
    logic [63:0] cx;
    int          post;
    int          e_nerr;
    logic        e_err;
    int          e_idx;
    logic [3:0]  e_lane;
  } vec_t;

  vec_t vecs [7];

  initial begin
    reset_n   = 1'b0;
    val       = 1'b0;
    msg       = '0;
    load_en   = 1'b0;
    load_addr = '0;
    load_msg  = '0;
    max_delay = '0;
    num_msgs  = '0;
`ifdef VC_TEST_SINK_MASK_EN
    load_mask = '0;
    mask_fill = '0;
`endif

    vecs[0] = '{0, 4,  -1, 64'd0,                    0, 0, 1'b0, 0, 4'h0};
    vecs[1] = '{7, 16, -1, 64'd0,                    0, 0, 1'b0, 0, 4'h0};
    vecs[2] = '{7, 16, -1, 64'd0,                    0, 0, 1'b0, 0, 4'h0};
    vecs[3] = '{3, 4,  2,  64'h0000_FFFF_0000_0000,  0, 1, 1'b1, 2, 4'b0100};
    vecs[4] = '{1, 5,  0,  64'h0000_0000_0000_0001,  0, 1, 1'b1, 0, 4'b0001};
    vecs[5] = '{2, 3,  1,  64'h8000_0000_0000_0001,  0, 1, 1'b1, 1, 4'b1001};
    vecs[6] = '{0, 2,  -1, 64'd0,                    3, 3, 1'b1, 2, 4'b1111};

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 16; i++) exp_mem[i] = {$urandom, $urandom};
      do_reset(vecs[v].md, vecs[v].n, vecs[v].n);
      run_stream(vecs[v].md, 0, vecs[v].n, vecs[v].ci, vecs[v].cx, vecs[v].post, 1'b1, 1'b1);
      chk($sformatf("v%0d_num_recv", v), num_recv, 64'(vecs[v].n));
      chk($sformatf("v%0d_done", v), done, 1);
      chk($sformatf("v%0d_num_err", v), num_err, 64'(vecs[v].e_nerr));
      chk($sformatf("v%0d_err", v), err, vecs[v].e_err);
      chk($sformatf("v%0d_err_idx", v), err_idx, 64'(vecs[v].e_idx));
      chk($sformatf("v%0d_err_lane", v), err_lane, vecs[v].e_lane);
    end

    // num_msgs==0 straight out of reset
    do_reset(0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("zero_msgs_done", done, 1);
    chk("zero_msgs_rdy", rdy, 0);

    // async reset mid-stream, then replay from index 0 against unchanged memory
    for (int i = 0; i < 16; i++) exp_mem[i] = {$urandom, $urandom};
    do_reset(2, 6, 6);
    run_stream(2, 0, 3, -1, 64'd0, 0, 1'b1, 1'b0);
    chk("midreset_pre_num_recv", num_recv, 3);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_num_recv", num_recv, 0);
    chk("midreset_rdy", rdy, 0);
    chk("midreset_done", done, 0);
    reset_n = 1'b1;
    run_stream(2, 0, 6, -1, 64'd0, 0, 1'b1, 1'b1);
    chk("replay_num_recv", num_recv, 6);
    chk("replay_num_err", num_err, 0);
    chk("replay_err", err, 0);

    // raising num_msgs while done resumes the stream
    for (int i = 0; i < 16; i++) exp_mem[i] = {$urandom, $urandom};
    do_reset(1, 2, 4);
    run_stream(1, 0, 2, -1, 64'd0, 0, 1'b1, 1'b1);
    num_msgs = 11'd4;
    @(posedge clk);
    @(negedge clk);
    chk("resume_done_low", done, 0);
    chk("resume_rdy_low", rdy, 0);
    run_stream(1, 2, 4, -1, 64'd0, 0, 1'b0, 1'b1);
    chk("resume_num_recv", num_recv, 4);
    chk("resume_num_err", num_err, 0);

`ifdef VC_TEST_SINK_MASK_EN
    // lane 0 masked as don't-care on every entry; corrupt lane 0 of message 1
    for (int i = 0; i < 16; i++) exp_mem[i] = {$urandom, $urandom};
    mask_fill = 64'h0000_0000_0000_FFFF;
    do_reset(2, 4, 4);
    run_stream(2, 0, 4, 1, 64'h0000_0000_0000_00FF, 0, 1'b1, 1'b1);
    chk("mask_num_err", num_err, 0);
    chk("mask_err", err, 0);
    mask_fill = '0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
